// File: rtl/reset_sequencer_spartan6.sv
// ============================================================================
// Module   : reset_sequencer_spartan6
// Purpose  : GSR stretch, lock-qualified settle, then staggered per-domain
//            reset release with soft-reset handshake and restart on lock loss.
//            Optional macro STARTUP_INST_EN instantiates STARTUP_SPARTAN6.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer_spartan6 #(
  parameter int N_DOMAINS      = 4,
  parameter int GSR_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 lock_i,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 gsr_o,
  output logic [N_DOMAINS-1:0] rst_domain_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int MAX_GS  = (GSR_CYCLES > SETTLE_CYCLES) ? GSR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_GS > STAGGER_CYCLES) ? MAX_GS : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(N_DOMAINS + 1);

  localparam logic [CNT_W-1:0] c_gsr_load     = CNT_W'(GSR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_load  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stagger_load = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_GSR     = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_DOMAINS-1:0]   rst_domain_q, rst_domain_d;
  logic                   gsr_q, gsr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic                   do_restart;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rst_domain_d = rst_domain_q;
    gsr_d        = gsr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    ack_d        = 1'b0;
    do_restart   = 1'b0;

    unique case (state_q)
      ST_GSR: begin
        gsr_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          gsr_d   = 1'b0;
          cnt_d   = c_settle_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (!lock_i) begin
          cnt_d = c_settle_load;
        end else if (cnt_q == '0) begin
          // Bits release lowest-first, so a left shift clears the next one.
          rst_domain_d = rst_domain_q << 1;
          idx_d        = IDX_W'(1);
          cnt_d        = c_stagger_load;
          state_d      = (N_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!lock_i) begin
          do_restart = 1'b1;
        end else if (cnt_q == '0) begin
          rst_domain_d = rst_domain_q << 1;
          cnt_d        = c_stagger_load;
          if (idx_q == c_last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        if (req_i || !lock_i) begin
          do_restart = 1'b1;
          ack_d      = req_i;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      default: do_restart = 1'b1;
    endcase

    if (do_restart) begin
      state_d      = ST_GSR;
      cnt_d        = c_gsr_load;
      idx_d        = '0;
      rst_domain_d = '1;
      gsr_d        = 1'b1;
      busy_d       = 1'b1;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ST_GSR;
      cnt_q        <= c_gsr_load;
      idx_q        <= '0;
      rst_domain_q <= '1;
      gsr_q        <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rst_domain_q <= rst_domain_d;
      gsr_q        <= gsr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ack_q        <= ack_d;
    end
  end

  assign ack_o        = ack_q;
  assign gsr_o        = gsr_q;
  assign rst_domain_o = rst_domain_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef STARTUP_INST_EN
  STARTUP_SPARTAN6 u_startup (
    .CFGCLK    (),
    .CFGMCLK   (),
    .CLK       (1'b0),
    .EOS       (),
    .GSR       (gsr_q),
    .GTS       (1'b0),
    .KEYCLEARB (1'b0)
  );
`else
  // gsr_o is routed to the device startup primitive by the enclosing top level.
`endif

endmodule

`default_nettype wire
